cp0: RTL and testbench

- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline.
- Sits beside the M stage and is the consumer of the exception codes produced by the E-stage ALU and other stages.
- Registers the victim PC, cause and status.
- Raises IntReq to flush the pipeline and redirect fetch to the handler.
- Serves mfc0/mtc0/eret.

---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_if.sv | 26 ++
 rtl/cp0.sv | 69 ++++++
 tb/tb_cp0.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block: register numbers, exception codes
// and the bit layout of the SR and Cause registers.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE         = 0;
  localparam int SR_EXL        = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD      = 31;

  // Only IM, EXL and IE are implemented in SR; all other bits read back as 0.
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

endpackage

// File: rtl/cp0_if.sv
// Pipeline-side bus of cp0: mfc0/mtc0 access, M-stage exception info and
// the flush/redirect outputs.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0 exception/interrupt controller: holds SR, Cause and EPC,
// raises IntReq to flush the pipeline, and serves mfc0/mtc0/eret.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2018
) (
  input  logic  clk,
  input  logic  reset,
  cp0_if.slave  bus
);

  logic [31:0] sr_reg, sr_next;
  logic [31:0] cause_reg, cause_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] epc_victim;
  logic        int_req, exc_req, take;

  assign int_req = (|(bus.HWInt & sr_reg[SR_IM_LSB +: 6])) & sr_reg[SR_IE] & ~sr_reg[SR_EXL];
  assign exc_req = (bus.ExcCode != EXC_INT) & ~sr_reg[SR_EXL];
  assign take    = int_req | exc_req;

  // A delay-slot victim restarts at the branch, one word earlier; wraps mod 2^32.
  assign epc_victim = (bus.PC & ~32'h3) - (bus.BD ? 32'd4 : 32'd0);

  always_comb begin
    sr_next    = sr_reg;
    cause_next = cause_reg;
    epc_next   = epc_reg;
    cause_next[CAUSE_IP_LSB +: 6] = bus.HWInt;
    if (take) begin
      sr_next[SR_EXL]                 = 1'b1;
      cause_next[CAUSE_BD]            = bus.BD;
      cause_next[CAUSE_EXC_LSB +: 5]  = int_req ? EXC_INT : bus.ExcCode;
      epc_next                        = epc_victim;
    end else begin
      if (bus.WE && bus.A2 == REG_SR)  sr_next  = bus.DIn & SR_MASK;
      if (bus.WE && bus.A2 == REG_EPC) epc_next = bus.DIn;
      // eret beats a same-cycle SR write for EXL only
      if (bus.EXLClr) sr_next[SR_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_reg    <= '0;
      cause_reg <= '0;
      epc_reg   <= '0;
    end else begin
      sr_reg    <= sr_next;
      cause_reg <= cause_next;
      epc_reg   <= epc_next;
    end
  end

  always_comb begin
    case (bus.A1)
      REG_SR:    bus.DOut = sr_reg;
      REG_CAUSE: bus.DOut = cause_reg;
      REG_EPC:   bus.DOut = epc_reg;
      REG_PRID:  bus.DOut = PRID_VALUE;
      default:   bus.DOut = 32'd0;
    endcase
  end

  assign bus.IntReq = take;
  assign bus.EPC    = epc_reg;

endmodule

// File: tb/tb_cp0.sv
// Scoreboard bench for cp0: stimulus pushes model predictions, a negedge
// monitor pops and compares IntReq, EPC and DOut.
module tb_cp0;

  localparam logic [31:0] PRID = 32'h0000_2018;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_if bus ();

  cp0 #(.PRID_VALUE(PRID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic [4:0]  a1;
    logic        intreq;
    logic [31:0] epc;
    logic [31:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_id   = 0;
  bit   stim_done = 0;

  // Architectural model: registers kept as the words software would read.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_intr(input logic [5:0] hw);
    return ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_excp(input logic [4:0] ec);
    return (ec != 5'd0) && !m_sr[1];
  endfunction

  task automatic vec(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] din, input logic we, input logic [31:0] pc,
                     input logic bd, input logic [4:0] ec, input logic [5:0] hw,
                     input logic clr, input bit chk);
    exp_t        e;
    logic        intr, req;
    logic [31:0] aligned;
    reset = r; bus.A1 = a1; bus.A2 = a2; bus.DIn = din; bus.WE = we; bus.PC = pc;
    bus.BD = bd; bus.ExcCode = ec; bus.HWInt = hw; bus.EXLClr = clr;
    intr = m_intr(hw);
    req  = intr || m_excp(ec);
    if (chk) begin
      e.id = n_id; e.a1 = a1; e.intreq = req; e.epc = m_epc; e.dout = m_read(a1);
      exp_q.push_back(e);
      n_id++;
    end
    @(posedge clk);
    if (r) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (req) begin
      m_sr[1] = 1'b1;
      m_cause = {bd, 15'd0, hw, 3'd0, (intr ? 5'd0 : ec), 2'd0};
      aligned = {pc[31:2], 2'b00};
      m_epc   = bd ? aligned - 32'd4 : aligned;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
      if (we && a2 == 5'd12) m_sr = din & 32'h0000_FC03;
      if (we && a2 == 5'd14) m_epc = din;
      if (clr) m_sr[1] = 1'b0;
    end
    #1;
  endtask

  // Shorthand for read-only / idle cycles.
  task automatic rd(input logic [4:0] a1, input logic [4:0] ec, input logic [5:0] hw,
                    input logic [31:0] pc, input logic bd);
    vec(1'b0, a1, 5'd0, 32'd0, 1'b0, pc, bd, ec, hw, 1'b0, 1'b1);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        $display("txn %0d: A1=%0d IntReq=%0b EPC=%h DOut=%h", e.id, e.a1, bus.IntReq, bus.EPC, bus.DOut);
        if (bus.IntReq !== e.intreq) begin
          n_miss++;
          $display("FAIL intreq txn %0d: got %0b want %0b", e.id, bus.IntReq, e.intreq);
        end
        if (bus.EPC !== e.epc) begin
          n_miss++;
          $display("FAIL epc txn %0d: got %h want %h", e.id, bus.EPC, e.epc);
        end
        if (bus.DOut !== e.dout) begin
          n_miss++;
          $display("FAIL dout txn %0d (A1=%0d): got %h want %h", e.id, e.a1, bus.DOut, e.dout);
        end
      end
    end
  end

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    // Initial reset edge: state is unknown before it, so nothing is checked.
    vec(1'b1, 5'd12, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
    vec(1'b1, 5'd13, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd3, 6'd0, 1'b0, 1'b1);
    rd(5'd12, 5'd0, 6'd0, 32'd0, 1'b0);

    // 1: enable IM/IE, read back, then take a hardware interrupt
    vec(1'b0, 5'd12, 5'd12, 32'h0000_FC01, 1'b1, 32'h100, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
    rd(5'd12, 5'd0, 6'd0, 32'h100, 1'b0);
    rd(5'd13, 5'd0, 6'b000100, 32'h104, 1'b0);
    rd(5'd13, 5'd0, 6'b000000, 32'h108, 1'b0);
    rd(5'd12, 5'd0, 6'b000100, 32'h108, 1'b0);

    // 2: clear SR, then overflow exception with IE=0
    vec(1'b0, 5'd12, 5'd12, 32'd0, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
    rd(5'd14, 5'd12, 6'd0, 32'h0000_3010, 1'b0);
    rd(5'd14, 5'd0, 6'd0, 32'h0, 1'b0);
    rd(5'd13, 5'd0, 6'd0, 32'h0, 1'b0);
    rd(5'd12, 5'd0, 6'd0, 32'h0, 1'b0);

    // 3: eret, then AdEL in a delay slot
    vec(1'b0, 5'd12, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1);
    rd(5'd13, 5'd4, 6'd0, 32'h0000_3024, 1'b1);
    rd(5'd13, 5'd0, 6'd0, 32'h0, 1'b0);
    rd(5'd14, 5'd0, 6'd0, 32'h0, 1'b0);

    // 4: nested events lost while EXL=1; pending interrupt taken after eret
    vec(1'b0, 5'd12, 5'd12, 32'h0000_FC03, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
    rd(5'd14, 5'd5, 6'b100000, 32'h0000_4000, 1'b0);
    rd(5'd14, 5'd5, 6'b100000, 32'h0000_4004, 1'b0);
    vec(1'b0, 5'd12, 5'd0, 32'd0, 1'b0, 32'h0000_4008, 1'b0, 5'd0, 6'b100000, 1'b1, 1'b1);
    rd(5'd14, 5'd0, 6'b100000, 32'h0000_500C, 1'b0);
    rd(5'd14, 5'd0, 6'd0, 32'h0, 1'b0);

    // 5: interrupt beats ExcCode=10 and a concurrent EPC write; BD=0 path; wrap
    vec(1'b0, 5'd12, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1);
    vec(1'b0, 5'd13, 5'd14, 32'hDEAD_BEEF, 1'b1, 32'h0000_6007, 1'b0, 5'd10, 6'b000001, 1'b0, 1'b1);
    rd(5'd13, 5'd0, 6'd0, 32'h0, 1'b0);
    vec(1'b0, 5'd12, 5'd12, 32'h0000_0001, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1);
    rd(5'd14, 5'd4, 6'd0, 32'h0, 1'b1);
    rd(5'd14, 5'd0, 6'd0, 32'h0, 1'b0);

    // 6: read-only Cause, PRId, unmapped read, EPC write, reset mid-handler
    vec(1'b0, 5'd13, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
    rd(5'd13, 5'd0, 6'd0, 32'h0, 1'b0);
    rd(5'd15, 5'd0, 6'd0, 32'h0, 1'b0);
    rd(5'd7, 5'd0, 6'd0, 32'h0, 1'b0);
    vec(1'b0, 5'd14, 5'd14, 32'h1234_5679, 1'b1, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1);
    rd(5'd14, 5'd0, 6'd0, 32'h0, 1'b0);
    vec(1'b1, 5'd12, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 5'd0, 6'd7, 1'b0, 1'b1);
    rd(5'd12, 5'd0, 6'd0, 32'h0, 1'b0);
    rd(5'd13, 5'd0, 6'd0, 32'h0, 1'b0);
    rd(5'd14, 5'd0, 6'd0, 32'h0, 1'b0);

    // Random phase
    for (int i = 0; i < 300; i++) begin
      logic [4:0] a2;
      case ($urandom_range(0, 4))
        0: a2 = 5'd12;
        1: a2 = 5'd13;
        2: a2 = 5'd14;
        3: a2 = 5'd15;
        default: a2 = 5'($urandom);
      endcase
      vec(($urandom_range(0, 49) == 0),
          5'($urandom_range(10, 17)), a2, $urandom, ($urandom_range(0, 2) == 0),
          $urandom, 1'($urandom),
          ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
          ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'd0,
          ($urandom_range(0, 3) == 0), 1'b1);
    end
    stim_done = 1;
  end

  initial begin
    wait (stim_done);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

endmodule
